geofence_n: RTL and testbench
=============================

Name: geofence_n

Overview:
- Parametrised successor to the 6-vertex geofence block. Receives one object point, then N vertices of a convex fence in arbitrary order, with N from 3 to N_MAX chosen per job.
- Sorts the vertices into counter-clockwise order around vertex 0, then tests the object point against every edge.
- Adds an in_valid/in_ready handshake, a runtime vertex count, a runtime edge-inclusion mode and an error flag.

Parameters:
W, 10, unsigned coordinate width
N_MAX, 8, maximum vertex count (at least 3); index width IW = clog2(N_MAX)+1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  beat on X/Y is valid
in_ready  output  1  block accepts a beat (high in IDLE and LOAD)
X  input  W  x coordinate of the beat
Y  input  W  y coordinate of the beat
num_vert  input  IW  vertex count; sampled with the object beat
edge_incl  input  1  1 = point on an edge counts as inside; sampled with the object beat
valid  output  1  one-cycle result strobe
is_inside  output  1  result; meaningful only while valid=1
err  output  1  num_vert illegal; meaningful only while valid=1

Behaviour:
- Reset: synchronous, active-high. valid=0, is_inside=0, err=0, state=IDLE, all counters 0. Reset asserted in any state aborts the job. No partial result is emitted.
- A beat is accepted when in_valid and in_ready are both 1. Gaps in in_valid are allowed. Beats are ignored while in_ready=0.
- IDLE:
  - Accepted beat gives the object point P. num_vert and edge_incl are latched from this beat.
  - If the latched n is below 3 or above N_MAX, go to DONE with err=1, is_inside=0.
  - Otherwise go to LOAD.
- LOAD:
  - Accepted beats fill v[0..n-1] in order.
  - After the beat for v[n-1], go to SORT with i=1, j=n-1.
- SORT (bubble sort, one compare per cycle):
  - c = (x[i]-x[0])*(y[i+1]-y[0]) - (x[i+1]-x[0])*(y[i]-y[0]).
  - If c < 0, swap v[i] and v[i+1].
  - If i == j-1 and j == 2, go to TEST with i=0.
  - Else if i == j-1: i=1, j=j-1.
  - Else i=i+1.
  - The sort takes S = (n-1)(n-2)/2 cycles.
- TEST (one edge per cycle, i = 0..n-1, next vertex k = (i+1) mod n):
  - e = (x[k]-x[i])*(Y_P-y[i]) - (y[k]-y[i])*(X_P-x[i]).
  - Edge fails if e < 0, or if e == 0 and edge_incl=0.
  - On the first failing edge: go to DONE, is_inside=0 (early exit).
  - If no edge fails after i = n-1: go to DONE, is_inside=1.
- DONE: valid=1 for exactly one cycle, then IDLE. In IDLE, valid=0 and is_inside/err hold their last value.
- Arithmetic:
  - Coordinates are zero-extended to W+1 signed before subtraction.
  - Products are 2W+2 signed; each cross result is 2W+3 signed. No overflow is possible.
- Latency: with the last vertex accepted in cycle L, SORT starts at L+1. valid is asserted in cycle L+S+k+1, where k = number of edges evaluated (k ≤ n).
- Illegal num_vert: valid is asserted in the cycle after the object beat.
- Input constraints: the fence is strictly convex and no three vertices are collinear. Behaviour outside these constraints is undefined but must not hang; the FSM always returns to IDLE.
- Back-to-back jobs: in_ready rises in the cycle after valid. A beat offered during DONE is not accepted.

Decomposition:
- geofence_pkg:
  - state enum: IDLE, LOAD, SORT, TEST, DONE.
  - localparams for IW and the cross-result width 2W+3.
  - function next_idx(i, n) implementing the mod-n wrap.
- Sub-module geofence_cross: combinational. Inputs are four W+1-bit signed differences; output is a 2W+3-bit signed cross product. It is instantiated once and shared by SORT and TEST through an operand mux.

Test Plan:
- Square, n=4, edge_incl=0: P=(5,5); vertices (0,0),(10,10),(10,0),(0,10) -> valid at L+8 (S=3, k=4), is_inside=1, err=0.
- Same square, P=(10,5) -> with edge_incl=0: is_inside=0. Re-run with edge_incl=1: is_inside=1.
- Hexagon, n=6, W=10: P=(500,500); vertices (600,300),(400,300),(300,500),(400,700),(600,700),(700,500) shuffled -> is_inside=1, valid at L+17. Repeat with P=(900,500) -> is_inside=0 with early exit, valid before L+17.
- num_vert=2 and num_vert=N_MAX+1 -> valid in the cycle after the object beat, err=1, is_inside=0; the next job runs normally.
- Reset asserted mid-SORT of a hexagon job -> next cycle valid=0, in_ready=1; a following triangle job P=(1,1), vertices (0,0),(4,0),(0,4) -> is_inside=1.
- W=12, N_MAX=8, n=8 octagon with coordinates near 4095, in_valid toggled every other cycle during LOAD -> correct result, no overflow, all stalled beats ignored.

Source files
------------

// File: rtl/geofence_pkg.sv
// geofence_pkg: shared state encoding, width helpers and index wrap for the geofence block
package geofence_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, SORT, TEST, DONE} state_t;
   localparam int W_DEF = 10;
   localparam int N_MAX_DEF = 8;
   localparam int IW_DEF = $clog2(N_MAX_DEF) + 1;
   localparam int CW_DEF = 2 * W_DEF + 3;
   function automatic int iw_of(input int n_max);
      return $clog2(n_max) + 1;
   endfunction
   function automatic int cw_of(input int w);
      return 2 * w + 3;
   endfunction
   function automatic int next_idx(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction
endpackage

// File: rtl/geofence_cross.sv
// geofence_cross: signed 2-D cross product a x b = ax*by - bx*ay
module geofence_cross #(
   parameter int W = 10
) (
   input  logic signed [W:0]     ax,
   input  logic signed [W:0]     ay,
   input  logic signed [W:0]     bx,
   input  logic signed [W:0]     by,
   output logic signed [2*W+2:0] c
);
   logic signed [2*W+1:0] p0, p1;
   assign p0 = ax * by;
   assign p1 = bx * ay;
   assign c = {p0[2*W+1], p0} - {p1[2*W+1], p1};
endmodule

// File: rtl/geofence_n.sv
// geofence_n: sorts up to N_MAX convex fence vertices CCW and tests a point against every edge
module geofence_n
   import geofence_pkg::*;
#(
   parameter int W = 10,
   parameter int N_MAX = 8,
   localparam int IW = iw_of(N_MAX)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  X,
   input  logic [W-1:0]  Y,
   input  logic [IW-1:0] num_vert,
   input  logic          edge_incl,
   output logic          valid,
   output logic          is_inside,
   output logic          err
);
   localparam int AW = $clog2(N_MAX);
   localparam int CW = cw_of(W);

   state_t state, nstate;
   logic [W-1:0] vx [N_MAX];
   logic [W-1:0] vy [N_MAX];
   logic [W-1:0] px, py;
   logic [IW-1:0] n, i, j, k;
   logic [AW-1:0] ia, ka, ia0;
   logic incl, illegal, last, pass_end, fail;
   logic signed [W:0] ax, ay, bx, by;
   logic signed [CW-1:0] c;

   function automatic logic signed [W:0] dif(input logic [W-1:0] a, input logic [W-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   assign illegal = num_vert < IW'(3) || num_vert > IW'(N_MAX);
   assign last = i == n - 1'b1;
   assign pass_end = i == j - 1'b1;
   assign k = (state == TEST) ? IW'(next_idx(int'(i), int'(n))) : i + 1'b1;
   assign ia = i[AW-1:0];
   assign ka = k[AW-1:0];
   assign ia0 = '0;
   // SORT compares v[i], v[i+1] around v[0]; TEST compares edge v[i]->v[k] against P
   assign ax = (state == TEST) ? dif(vx[ka], vx[ia]) : dif(vx[ia], vx[ia0]);
   assign ay = (state == TEST) ? dif(vy[ka], vy[ia]) : dif(vy[ia], vy[ia0]);
   assign bx = (state == TEST) ? dif(px, vx[ia]) : dif(vx[ka], vx[ia0]);
   assign by = (state == TEST) ? dif(py, vy[ia]) : dif(vy[ka], vy[ia0]);
   assign fail = c[CW-1] || (c == '0 && !incl);
   assign in_ready = state == IDLE || state == LOAD;
   assign valid = state == DONE;

   geofence_cross #(.W(W)) u_cross (
      .ax(ax),
      .ay(ay),
      .bx(bx),
      .by(by),
      .c (c)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= nstate;
   end

   // next-state selection
   always_comb begin
      nstate = state;
      case (state)
         IDLE: if (in_valid) nstate = illegal ? DONE : LOAD;
         LOAD: if (in_valid && last) nstate = SORT;
         SORT: if (pass_end && j == IW'(2)) nstate = TEST;
         TEST: if (fail || last) nstate = DONE;
         default: nstate = IDLE;
      endcase
   end

   // job parameters, vertex storage, sort/test indices and result flags
   always_ff @(posedge clk) begin
      if (reset) begin
         px <= '0;
         py <= '0;
         n <= '0;
         i <= '0;
         j <= '0;
         incl <= 1'b0;
         is_inside <= 1'b0;
         err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               px <= X;
               py <= Y;
               n <= num_vert;
               incl <= edge_incl;
               i <= '0;
               err <= illegal;
               if (illegal) is_inside <= 1'b0;
            end
            LOAD: if (in_valid) begin
               vx[ia] <= X;
               vy[ia] <= Y;
               i <= last ? IW'(1) : i + 1'b1;
               if (last) j <= n - 1'b1;
            end
            SORT: begin
               if (c[CW-1]) begin
                  vx[ia] <= vx[ka];
                  vy[ia] <= vy[ka];
                  vx[ka] <= vx[ia];
                  vy[ka] <= vy[ia];
               end
               i <= pass_end ? ((j == IW'(2)) ? '0 : IW'(1)) : i + 1'b1;
               if (pass_end) j <= j - 1'b1;
            end
            TEST: begin
               if (fail) is_inside <= 1'b0;
               else if (last) is_inside <= 1'b1;
               i <= i + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_geofence_n.sv
// tb_geofence_n: directed geofence jobs with hand-computed results and latencies
module tb_geofence_n;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, edge_incl = 1'b0, sel = 1'b0;
   logic [11:0] x = '0, y = '0;
   logic [3:0] num_vert = '0;
   logic in_ready_a, valid_a, is_inside_a, err_a;
   logic in_ready_b, valid_b, is_inside_b, err_b;
   logic o_ready, o_valid, o_inside, o_err;
   int total = 0, bad = 0;

   int sq_x[8] = '{0, 10, 10, 0, 0, 0, 0, 0};
   int sq_y[8] = '{0, 10, 0, 10, 0, 0, 0, 0};
   int hx_x[8] = '{600, 400, 700, 300, 600, 400, 0, 0};
   int hx_y[8] = '{300, 700, 500, 500, 700, 300, 0, 0};
   int tr_x[8] = '{0, 4, 0, 0, 0, 0, 0, 0};
   int tr_y[8] = '{0, 0, 4, 0, 0, 0, 0, 0};
   int oc_x[8] = '{2895, 0, 4095, 1200, 0, 4095, 2895, 1200};
   int oc_y[8] = '{4095, 1200, 1200, 0, 2895, 2895, 0, 4095};

   always #5 clk = ~clk;

   geofence_n #(.W(10), .N_MAX(8)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(in_ready_a),
      .X(x[9:0]), .Y(y[9:0]), .num_vert(num_vert), .edge_incl(edge_incl),
      .valid(valid_a), .is_inside(is_inside_a), .err(err_a)
   );

   geofence_n #(.W(12), .N_MAX(8)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(in_ready_b),
      .X(x), .Y(y), .num_vert(num_vert), .edge_incl(edge_incl),
      .valid(valid_b), .is_inside(is_inside_b), .err(err_b)
   );

   assign o_ready = sel ? in_ready_b : in_ready_a;
   assign o_valid = sel ? valid_b : valid_a;
   assign o_inside = sel ? is_inside_b : is_inside_a;
   assign o_err = sel ? err_b : err_a;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input string tag, input int nv, input bit inc, input int px, input int py,
                          input int vx[8], input int vy[8], input bit gap,
                          input int exp_in, input int exp_err, input int exp_lat);
      int nb, lat;
      nb = (nv >= 3 && nv <= 8) ? nv : 0;
      in_valid = 1'b1;
      x = 12'(px);
      y = 12'(py);
      num_vert = 4'(nv);
      edge_incl = inc;
      step();
      for (int b = 0; b < nb; b++) begin
         if (gap) begin
            in_valid = 1'b0;
            x = 12'hABC;
            y = 12'h123;
            step();
         end
         in_valid = 1'b1;
         x = 12'(vx[b]);
         y = 12'(vy[b]);
         step();
      end
      in_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 200) begin
         step();
         lat++;
      end
      chk({tag, " valid"}, 32'(o_valid), 1);
      if (exp_lat >= 0) chk({tag, " lat"}, lat, exp_lat);
      chk({tag, " inside"}, 32'(o_inside), exp_in);
      chk({tag, " err"}, 32'(o_err), exp_err);
      chk({tag, " ready_in_done"}, 32'(o_ready), 0);
      step();
      chk({tag, " valid_drop"}, 32'(o_valid), 0);
      chk({tag, " ready_back"}, 32'(o_ready), 1);
      chk({tag, " inside_hold"}, 32'(o_inside), exp_in);
   endtask

   initial begin
      step();
      step();
      chk("rst valid", 32'(valid_a), 0);
      chk("rst ready", 32'(in_ready_a), 1);
      chk("rst inside", 32'(is_inside_a), 0);
      chk("rst err", 32'(err_a), 0);
      reset = 1'b0;
      step();
      run_job("sq_in", 4, 1'b0, 5, 5, sq_x, sq_y, 1'b0, 1, 0, 8);
      run_job("bad2", 2, 1'b0, 5, 5, sq_x, sq_y, 1'b0, 0, 1, 1);
      run_job("sq_edge_excl", 4, 1'b0, 10, 5, sq_x, sq_y, 1'b0, 0, 0, 6);
      run_job("sq_edge_incl", 4, 1'b1, 10, 5, sq_x, sq_y, 1'b0, 1, 0, 8);
      run_job("bad9", 9, 1'b0, 5, 5, sq_x, sq_y, 1'b0, 0, 1, 1);
      run_job("hex_in", 6, 1'b0, 500, 500, hx_x, hx_y, 1'b0, 1, 0, 17);
      run_job("hex_out", 6, 1'b0, 900, 500, hx_x, hx_y, 1'b0, 0, 0, 12);
      run_job("sq_again", 4, 1'b0, 5, 5, sq_x, sq_y, 1'b0, 1, 0, 8);
      in_valid = 1'b1;
      x = 12'd500;
      y = 12'd500;
      num_vert = 4'd6;
      step();
      for (int b = 0; b < 6; b++) begin
         x = 12'(hx_x[b]);
         y = 12'(hx_y[b]);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      chk("rst_sort valid", 32'(valid_a), 0);
      chk("rst_sort ready", 32'(in_ready_a), 1);
      reset = 1'b0;
      run_job("tri", 3, 1'b0, 1, 1, tr_x, tr_y, 1'b0, 1, 0, 5);
      sel = 1'b1;
      run_job("oct_in", 8, 1'b0, 2048, 2048, oc_x, oc_y, 1'b1, 1, 0, 30);
      run_job("oct_out", 8, 1'b0, 4095, 4095, oc_x, oc_y, 1'b1, 0, 0, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
